// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes and channel FSM states.
// Used by the slave register bank and by the matching master.
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (AW/W/B and AR/R) with master and slave views.
interface axi_lite_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_W-1:0]     WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// Word register storage: R/W words 0..NUM_REGS-2 plus a constant ID word at NUM_REGS-1.
// Write port reports hits on the read-only word; read port is combinational.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned NUM_REGS = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic                              we_i,
  input  logic [IDX_W-1:0]                  wr_idx_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  output logic                              ro_hit_o,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic [NUM_REGS-2:0][DATA_W-1:0]   regs_o
);

  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  logic [NUM_REGS-2:0][DATA_W-1:0] regs_q;
  logic [DATA_W-1:0]               rd_tbl [NUM_REGS];

  assign ro_hit_o = (wr_idx_i == ID_IDX);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
        if (we_i && (wr_idx_i == IDX_W'(i))) regs_q[i] <= wr_data_i;
      end
    end
  end

  // Full-size lookup table so the ID word shares the read mux with the storage.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS) - 1; i++) rd_tbl[i] = regs_q[i];
    rd_tbl[NUM_REGS-1] = ID_VALUE;
  end

  assign rd_data_o = rd_tbl[rd_idx_i];
  assign regs_o    = regs_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write (AW/W/B) and read (AR/R) channel FSMs
// around an axi_lite_regfile; one outstanding transaction per direction.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  axi_lite_if.slave                       s_axi,
  output logic [NUM_REGS-2:0][DATA_W-1:0] regs_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  wr_state_e          wr_state_q;
  logic               aw_full_q, w_full_q;
  logic [IDX_W-1:0]   awidx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               awready_q, wready_q, bvalid_q;
  resp_e              bresp_q;

  rd_state_e          rd_state_q;
  logic               arready_q, rvalid_q;
  logic [DATA_W-1:0]  rdata_q;
  resp_e              rresp_q;

  logic               aw_hs, w_hs, ar_hs, commit, ro_hit;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [DATA_W-1:0]  wr_data, rd_data;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign aw_hs = s_axi.AWVALID & awready_q;
  assign w_hs  = s_axi.WVALID & wready_q;
  assign ar_hs = s_axi.ARVALID & arready_q;

  // Each half comes from its latch if captured earlier, else from the live channel.
  assign wr_idx  = aw_full_q ? awidx_q : s_axi.AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_full_q  ? wdata_q : s_axi.WDATA;
  assign commit  = (wr_state_q == WR_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign rd_idx  = s_axi.ARADDR[ADDR_WIDTH-1:2];

  axi_lite_regfile #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .we_i      (commit),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .ro_hit_o  (ro_hit),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data),
    .regs_o    (regs_o)
  );

  // Write channel FSM with AW/W latches.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_q <= WR_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (commit) begin
            wr_state_q <= WR_RESP;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= ro_hit ? SLVERR : OKAY;
          end else begin
            if (aw_hs) begin
              aw_full_q <= 1'b1;
              awidx_q   <= s_axi.AWADDR[ADDR_WIDTH-1:2];
              awready_q <= 1'b0;
            end
            if (w_hs) begin
              w_full_q <= 1'b1;
              wdata_q  <= s_axi.WDATA;
              wready_q <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.BREADY) begin
            wr_state_q <= WR_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // Read channel FSM; data is sampled at the AR handshake, before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= RD_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_data;
            rresp_q    <= OKAY;
          end
        end
        RD_DATA: begin
          if (s_axi.RREADY) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed plus randomized bench for axi_lite_slave_regs against an array-based register model.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned NR = 4;
  localparam logic [31:0] IDV = 32'hA11E_0001;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_lite_if #(.ADDR_WIDTH(AW)) bus ();
  logic [NR-2:0][31:0] regs_o;

  axi_lite_slave_regs #(
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .ID_VALUE   (IDV)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (bus.slave),
    .regs_o  (regs_o)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mdl [NR-1];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [127:0] exp_regs();
    logic [127:0] v = '0;
    for (int i = 0; i < int'(NR) - 1; i++) v[i*32 +: 32] = mdl[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
    return (idx_of(a) == int'(NR) - 1) ? IDV : mdl[idx_of(a)];
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
    if (idx_of(a) != int'(NR) - 1) mdl[idx_of(a)] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR) - 1; i++) mdl[i] = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bvalid"},  128'(bus.BVALID),  128'(0));
    chk({tag, "_rvalid"},  128'(bus.RVALID),  128'(0));
    chk({tag, "_awready"}, 128'(bus.AWREADY), 128'(1));
    chk({tag, "_wready"},  128'(bus.WREADY),  128'(1));
    chk({tag, "_arready"}, 128'(bus.ARREADY), 128'(1));
    chk({tag, "_regs"},    128'(regs_o),      exp_regs());
  endtask

  task automatic b_ack(input logic [1:0] er, input int bdly);
    for (int i = 0; i < bdly; i++) begin
      step();
      chk("bhold_bvalid",  128'(bus.BVALID),  128'(1));
      chk("bhold_bresp",   128'(bus.BRESP),   128'(er));
      chk("bhold_awready", 128'(bus.AWREADY), 128'(0));
      chk("bhold_wready",  128'(bus.WREADY),  128'(0));
    end
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    chk("back_bvalid",  128'(bus.BVALID),  128'(0));
    chk("back_awready", 128'(bus.AWREADY), 128'(1));
    chk("back_wready",  128'(bus.WREADY),  128'(1));
  endtask

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW first; 0: same cycle.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input int lead, input int bdly);
    logic [1:0] er;
    er = (idx_of(a) == int'(NR) - 1) ? 2'b10 : 2'b00;
    bus.AWADDR = a;
    bus.WDATA  = d;
    if (lead == 0) begin
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      step();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
    end else if (lead > 0) begin
      bus.WVALID = 1'b1;
      step();
      bus.WVALID = 1'b0;
      chk("wfirst_wready", 128'(bus.WREADY), 128'(0));
      for (int i = 1; i < lead; i++) begin
        step();
        chk("wwait_wready", 128'(bus.WREADY), 128'(0));
        chk("wwait_bvalid", 128'(bus.BVALID), 128'(0));
      end
      bus.AWVALID = 1'b1;
      step();
      bus.AWVALID = 1'b0;
    end else begin
      bus.AWVALID = 1'b1;
      step();
      bus.AWVALID = 1'b0;
      chk("awfirst_awready", 128'(bus.AWREADY), 128'(0));
      for (int i = 1; i < -lead; i++) begin
        step();
        chk("awwait_awready", 128'(bus.AWREADY), 128'(0));
        chk("awwait_bvalid",  128'(bus.BVALID),  128'(0));
      end
      bus.WVALID = 1'b1;
      step();
      bus.WVALID = 1'b0;
    end
    model_write(a, d);
    chk("wr_bvalid",  128'(bus.BVALID),  128'(1));
    chk("wr_bresp",   128'(bus.BRESP),   128'(er));
    chk("wr_regs",    128'(regs_o),      exp_regs());
    chk("wr_awready", 128'(bus.AWREADY), 128'(0));
    b_ack(er, bdly);
  endtask

  task automatic r_ack(input logic [31:0] e, input int rdly);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("rhold_rvalid",  128'(bus.RVALID),  128'(1));
      chk("rhold_rdata",   128'(bus.RDATA),   128'(e));
      chk("rhold_arready", 128'(bus.ARREADY), 128'(0));
    end
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    chk("rack_rvalid",  128'(bus.RVALID),  128'(0));
    chk("rack_arready", 128'(bus.ARREADY), 128'(1));
  endtask

  task automatic rd(input logic [AW-1:0] a, input int rdly);
    logic [31:0] e;
    e = exp_read(a);
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    chk("rd_rvalid",  128'(bus.RVALID),  128'(1));
    chk("rd_rdata",   128'(bus.RDATA),   128'(e));
    chk("rd_rresp",   128'(bus.RRESP),   128'(0));
    chk("rd_arready", 128'(bus.ARREADY), 128'(0));
    r_ack(e, rdly);
  endtask

  initial begin
    logic [31:0] e;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    model_reset();
    step();
    step();
    ARESETn = 1'b1;
    step();
    chk_idle("reset");
    chk("reset_bresp", 128'(bus.BRESP), 128'(0));
    chk("reset_rresp", 128'(bus.RRESP), 128'(0));
    chk("reset_rdata", 128'(bus.RDATA), 128'(0));

    // Same-cycle AW/W, then W-first and AW-first with a 3-cycle gap.
    wr(4'h4, 32'hDEAD_BEEF, 0, 0);
    wr(4'h8, 32'h1234_5678, 3, 0);
    wr(4'h8, 32'h0BAD_F00D, -3, 0);
    // Read-only word: SLVERR, no update; ID readback; unaligned address decode.
    wr(4'hC, 32'h1, 0, 0);
    rd(4'hC, 0);
    wr(4'h5, 32'hCAFE_0001, 1, 2);
    rd(4'h7, 1);

    // Long B stall with a second AW offered that must wait for the B handshake.
    wr(4'h0, 32'h0000_00AA, 0, 0);
    bus.AWADDR = 4'h4; bus.WDATA = 32'h5A5A_5A5A;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    // Re-issue a fresh write and stall its response.
    bus.AWVALID = 1'b0;
    bus.AWADDR = 4'h0; bus.WDATA = 32'h0000_0077;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    bus.AWADDR = 4'h4;
    model_write(4'h0, 32'h0000_0077);
    chk("stall_bvalid0", 128'(bus.BVALID), 128'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_bvalid",  128'(bus.BVALID),  128'(1));
      chk("stall_bresp",   128'(bus.BRESP),   128'(0));
      chk("stall_awready", 128'(bus.AWREADY), 128'(0));
      chk("stall_wready",  128'(bus.WREADY),  128'(0));
    end
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    chk("stall_back_bvalid",  128'(bus.BVALID),  128'(0));
    chk("stall_back_awready", 128'(bus.AWREADY), 128'(1));
    step();
    bus.AWVALID = 1'b0;
    chk("stall_aw2_awready", 128'(bus.AWREADY), 128'(0));
    chk("stall_aw2_bvalid",  128'(bus.BVALID),  128'(0));
    bus.WDATA = 32'h5A5A_5A5A;
    bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    model_write(4'h4, 32'h5A5A_5A5A);
    chk("stall_aw2_commit", 128'(bus.BVALID), 128'(1));
    chk("stall_aw2_regs",   128'(regs_o),     exp_regs());
    b_ack(2'b00, 0);

    // Read and commit to the same word at the same edge: read sees the old value.
    wr(4'h0, 32'h5, 0, 0);
    e = exp_read(4'h0);
    bus.AWADDR = 4'h0; bus.WDATA = 32'h9; bus.ARADDR = 4'h0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    model_write(4'h0, 32'h9);
    chk("coll_rdata",  128'(bus.RDATA),  128'(e));
    chk("coll_rvalid", 128'(bus.RVALID), 128'(1));
    chk("coll_bvalid", 128'(bus.BVALID), 128'(1));
    chk("coll_regs",   128'(regs_o),     exp_regs());
    r_ack(e, 4);
    b_ack(2'b00, 0);
    rd(4'h0, 0);

    // Reset with both responses pending.
    bus.AWADDR = 4'h4; bus.WDATA = 32'h7777_7777; bus.ARADDR = 4'h4;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    chk("prerst_bvalid", 128'(bus.BVALID), 128'(1));
    chk("prerst_rvalid", 128'(bus.RVALID), 128'(1));
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    model_reset();
    chk_idle("midrst");

    // A latched AW is dropped by reset; a later lone W must not commit.
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    chk("drop_awready", 128'(bus.AWREADY), 128'(0));
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    chk("drop_awready_rst", 128'(bus.AWREADY), 128'(1));
    bus.WDATA = 32'h3C3C_3C3C; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    step();
    chk("drop_no_commit", 128'(bus.BVALID), 128'(0));
    chk("drop_regs",      128'(regs_o),     exp_regs());
    bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    model_write(4'h8, 32'h3C3C_3C3C);
    chk("drop_commit", 128'(bus.BVALID), 128'(1));
    chk("drop_regs2",  128'(regs_o),     exp_regs());
    b_ack(2'b00, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        wr(AW'($urandom), $urandom, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else
        rd(AW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
